// File: rtl/unidade_controle.sv
// ---------------------------------------------------------------------------
// unidade_controle
// Moore control FSM for the memory-game datapath (fluxo_dados).
// It plays back the stored colour sequence on the LEDs, collects and checks
// the player's moves, appends a new player-chosen colour at the end of each
// round, and stops on a win, a mistake or an inactivity timeout.
//
// Ports
//   clock, reset          : clock; asynchronous active-high reset -> inicial
//   iniciar               : start/restart request (level)
//   igual .. timeout_habilitado : status flags from fluxo_dados
//   zera_*/conta_*/...    : datapath command strobes
//   pronto/acertou/errou  : game-over indications
//   db_timeout            : loss was caused by the inactivity timeout
//   db_estado             : current state code (debug)
// ---------------------------------------------------------------------------
module unidade_controle #(
    parameter logic TIMEOUT_NA_ESCRITA = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       igual,
    input  logic       fim_jogo,
    input  logic       enderecoIgualLimite,
    input  logic       jogada_feita,
    input  logic       timeout,
    input  logic       timeout_led,
    input  logic       fim_sequencia,
    input  logic       timeout_habilitado,
    output logic       zera_endereco,
    output logic       conta_endereco,
    output logic       zera_limite,
    output logic       conta_limite,
    output logic       zeraR,
    output logic       registrarR,
    output logic       zera_s_timeout,
    output logic       enable_timeout,
    output logic       registra_modo,
    output logic       zera_modo,
    output logic       conf_leds,
    output logic       registra_jogada,
    output logic       zera_s_led,
    output logic       enable_led,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       db_timeout,
    output logic [4:0] db_estado
);

    localparam logic [4:0] ST_INICIAL        = 5'h00;
    localparam logic [4:0] ST_PREPARACAO     = 5'h01;
    localparam logic [4:0] ST_INICIO_RODADA  = 5'h02;
    localparam logic [4:0] ST_MOSTRA_LED     = 5'h03;
    localparam logic [4:0] ST_APAGA_LED      = 5'h04;
    localparam logic [4:0] ST_PROXIMO_LED    = 5'h05;
    localparam logic [4:0] ST_FIM_MOSTRA     = 5'h06;
    localparam logic [4:0] ST_ESPERA_JOGADA  = 5'h07;
    localparam logic [4:0] ST_REGISTRA       = 5'h08;
    localparam logic [4:0] ST_COMPARACAO     = 5'h09;
    localparam logic [4:0] ST_PROX_ENDERECO  = 5'h0A;
    localparam logic [4:0] ST_PROXIMA_RODADA = 5'h0B;
    localparam logic [4:0] ST_FIM_ACERTO     = 5'h0C;
    localparam logic [4:0] ST_FIM_ERRO       = 5'h0D;
    localparam logic [4:0] ST_FIM_TIMEOUT    = 5'h0E;
    localparam logic [4:0] ST_ESPERA_ESCRITA = 5'h0F;
    localparam logic [4:0] ST_ESCREVE        = 5'h10;

    logic [4:0] estado_q;
    logic [4:0] estado_d;

    // Timeout in the write-wait state is only honoured when enabled at build time.
    logic timeout_escrita_hab;
    assign timeout_escrita_hab = timeout_habilitado & TIMEOUT_NA_ESCRITA;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= ST_INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic
    always_comb begin
        estado_d = ST_INICIAL;
        case (estado_q)
            ST_INICIAL:        estado_d = iniciar ? ST_PREPARACAO : ST_INICIAL;
            ST_PREPARACAO:     estado_d = ST_INICIO_RODADA;
            ST_INICIO_RODADA:  estado_d = ST_MOSTRA_LED;
            ST_MOSTRA_LED:     estado_d = timeout_led ? ST_APAGA_LED : ST_MOSTRA_LED;
            ST_APAGA_LED: begin
                if (!timeout_led)             estado_d = ST_APAGA_LED;
                else if (enderecoIgualLimite) estado_d = ST_FIM_MOSTRA;
                else                          estado_d = ST_PROXIMO_LED;
            end
            ST_PROXIMO_LED:    estado_d = ST_MOSTRA_LED;
            ST_FIM_MOSTRA:     estado_d = ST_ESPERA_JOGADA;
            ST_ESPERA_JOGADA: begin
                // A move seen in the same cycle as the timeout wins.
                if (jogada_feita)                         estado_d = ST_REGISTRA;
                else if (timeout && timeout_habilitado)   estado_d = ST_FIM_TIMEOUT;
                else                                      estado_d = ST_ESPERA_JOGADA;
            end
            ST_REGISTRA:       estado_d = ST_COMPARACAO;
            ST_COMPARACAO: begin
                // A mismatch overrides every other flag.
                if (!igual)             estado_d = ST_FIM_ERRO;
                else if (fim_sequencia) estado_d = fim_jogo ? ST_FIM_ACERTO : ST_PROXIMA_RODADA;
                else                    estado_d = ST_PROX_ENDERECO;
            end
            ST_PROX_ENDERECO:  estado_d = ST_ESPERA_JOGADA;
            ST_PROXIMA_RODADA: estado_d = ST_ESPERA_ESCRITA;
            ST_ESPERA_ESCRITA: begin
                if (jogada_feita)                         estado_d = ST_ESCREVE;
                else if (timeout && timeout_escrita_hab)  estado_d = ST_FIM_TIMEOUT;
                else                                      estado_d = ST_ESPERA_ESCRITA;
            end
            ST_ESCREVE:        estado_d = ST_INICIO_RODADA;
            ST_FIM_ACERTO:     estado_d = iniciar ? ST_PREPARACAO : ST_FIM_ACERTO;
            ST_FIM_ERRO:       estado_d = iniciar ? ST_PREPARACAO : ST_FIM_ERRO;
            ST_FIM_TIMEOUT:    estado_d = iniciar ? ST_PREPARACAO : ST_FIM_TIMEOUT;
            default:           estado_d = ST_INICIAL;
        endcase
    end

    // Output decode
    always_comb begin
        zera_endereco   = 1'b0;
        conta_endereco  = 1'b0;
        zera_limite     = 1'b0;
        conta_limite    = 1'b0;
        zeraR           = 1'b0;
        registrarR      = 1'b0;
        zera_s_timeout  = 1'b0;
        enable_timeout  = 1'b0;
        registra_modo   = 1'b0;
        zera_modo       = 1'b0;
        conf_leds       = 1'b0;
        registra_jogada = 1'b0;
        zera_s_led      = 1'b0;
        enable_led      = 1'b0;
        pronto          = 1'b0;
        acertou         = 1'b0;
        errou           = 1'b0;
        db_timeout      = 1'b0;
        case (estado_q)
            ST_PREPARACAO: begin
                zera_endereco  = 1'b1;
                zera_limite    = 1'b1;
                zeraR          = 1'b1;
                zera_s_timeout = 1'b1;
                zera_s_led     = 1'b1;
                registra_modo  = 1'b1;
            end
            ST_INICIO_RODADA: begin
                zera_endereco = 1'b1;
                zera_s_led    = 1'b1;
            end
            ST_MOSTRA_LED: begin
                conf_leds  = 1'b1;
                enable_led = 1'b1;
            end
            ST_APAGA_LED:      enable_led = 1'b1;
            ST_PROXIMO_LED: begin
                conta_endereco = 1'b1;
                zera_s_led     = 1'b1;
            end
            ST_FIM_MOSTRA: begin
                zera_endereco  = 1'b1;
                zeraR          = 1'b1;
                zera_s_timeout = 1'b1;
            end
            ST_ESPERA_JOGADA:  enable_timeout = timeout_habilitado;
            ST_REGISTRA:       registrarR = 1'b1;
            ST_PROX_ENDERECO: begin
                conta_endereco = 1'b1;
                zera_s_timeout = 1'b1;
            end
            ST_PROXIMA_RODADA: begin
                conta_endereco = 1'b1;
                conta_limite   = 1'b1;
                zera_s_timeout = 1'b1;
            end
            ST_ESPERA_ESCRITA: enable_timeout = timeout_escrita_hab;
            ST_ESCREVE:        registra_jogada = 1'b1;
            ST_FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            ST_FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            ST_FIM_TIMEOUT: begin
                pronto     = 1'b1;
                errou      = 1'b1;
                db_timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule
